// File: rtl/z80_exec_alu_a_idx_ixiy.sv
// Execution sequencer for the 8-bit ALU group on an indexed operand:
// ADD/ADC/SUB/SBC/AND/XOR/OR/CP A,(IX/IY+d), encoded DD/FD 10ooo110 dd.
// Fetches the three instruction bytes, waits for the address calculation,
// reads the operand, then presents A/F and the z80fi trace record for one
// cycle together with the done pulse.
module z80_exec_alu_a_idx_ixiy #(
  parameter int CALC_CYCLES = 5
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [15:0] ip_i,
  input  logic [7:0]  a_i,
  input  logic [7:0]  f_i,
  input  logic [15:0] ix_i,
  input  logic [15:0] iy_i,
  output logic        busy_o,
  output logic        mem_rd_o,
  output logic [15:0] mem_addr_o,
  input  logic [7:0]  mem_rdata_i,
  input  logic        mem_ready_i,
  output logic        done_o,
  output logic        illegal_o,
  output logic [7:0]  a_o,
  output logic [7:0]  f_o,
  output logic [15:0] ip_o,
  output logic        z80fi_valid_o,
  output logic [31:0] z80fi_insn_o,
  output logic [3:0]  z80fi_insn_len_o,
  output logic [15:0] z80fi_mem_raddr_o,
  output logic [7:0]  z80fi_mem_rdata_o
);

  // The countdown is loaded with CALC_CYCLES-1 so the CALC state lasts
  // exactly CALC_CYCLES cycles.
  localparam logic [3:0] CALC_LOAD = 4'(CALC_CYCLES - 1);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_ADC = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_SBC = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_OR  = 3'd6;
  localparam logic [2:0] OP_CP  = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_F0,
    S_F1,
    S_F2,
    S_CALC,
    S_RD,
    S_EX
  } state_t;

  state_t      state_q;
  logic        busy_q;
  logic        mem_rd_q;
  logic [15:0] mem_addr_q;
  logic        done_q;
  logic        illegal_q;
  logic [7:0]  a_out_q;
  logic [7:0]  f_out_q;
  logic [15:0] ip_out_q;
  logic [31:0] insn_q;
  logic [3:0]  insn_len_q;
  logic [15:0] trace_raddr_q;
  logic [7:0]  trace_rdata_q;

  // Values captured when start is accepted and during the fetches.
  logic [15:0] ip_q;
  logic [7:0]  a_q;
  logic [7:0]  f_q;
  logic [15:0] ix_q;
  logic [15:0] iy_q;
  logic [7:0]  prefix_q;
  logic [7:0]  opc_q;
  logic [7:0]  d_q;
  logic [3:0]  cnt_q;

  // ALU and address-calculation results feeding the FSM.
  logic [7:0]  a_d;
  logic [7:0]  f_d;
  logic [15:0] raddr_d;

  logic [2:0]  op;
  logic        is_sub;
  logic        cin;
  logic        ci;
  logic [7:0]  b;
  logic [8:0]  sum9;
  logic [4:0]  nib5;
  logic [7:0]  r;
  logic        h;
  logic        pv;
  logic        c;

  // Operand address: selected index register plus sign-extended displacement.
  always_comb begin
    raddr_d = ((prefix_q == 8'hFD) ? iy_q : ix_q) + {{8{d_q[7]}}, d_q};
  end

  // ALU on the operand byte as it arrives in the RD state.
  always_comb begin
    op     = opc_q[5:3];
    is_sub = (op == OP_SUB) || (op == OP_SBC) || (op == OP_CP);
    cin    = ((op == OP_ADC) || (op == OP_SBC)) && f_q[0];
    // Subtraction is an add of the complemented operand with inverted carry-in.
    b      = is_sub ? ~mem_rdata_i : mem_rdata_i;
    ci     = is_sub ? ~cin : cin;
    sum9   = {1'b0, a_q} + {1'b0, b} + {8'd0, ci};
    nib5   = {1'b0, a_q[3:0]} + {1'b0, b[3:0]} + {4'd0, ci};
    r      = sum9[7:0];
    // Subtracts report both half-carry and carry as borrows.
    h      = nib5[4] ^ is_sub;
    pv     = (a_q[7] == b[7]) && (sum9[7] != a_q[7]);
    c      = sum9[8] ^ is_sub;
    case (op)
      OP_AND: begin
        r  = a_q & mem_rdata_i;
        h  = 1'b1;
        pv = ~^r;
        c  = 1'b0;
      end
      OP_XOR: begin
        r  = a_q ^ mem_rdata_i;
        h  = 1'b0;
        pv = ~^r;
        c  = 1'b0;
      end
      OP_OR: begin
        r  = a_q | mem_rdata_i;
        h  = 1'b0;
        pv = ~^r;
        c  = 1'b0;
      end
      OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_CP: begin
        r = sum9[7:0];
      end
      default: begin
        r = sum9[7:0];
      end
    endcase
    // CP only sets flags; A is left untouched.
    a_d = (op == OP_CP) ? a_q : r;
    f_d = {r[7], (r == 8'd0), f_q[5], h, f_q[3], pv, is_sub, c};
  end

  // Instruction sequencer with registered memory, status and result outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= S_IDLE;
      busy_q        <= 1'b0;
      mem_rd_q      <= 1'b0;
      mem_addr_q    <= 16'd0;
      done_q        <= 1'b0;
      illegal_q     <= 1'b0;
      a_out_q       <= 8'd0;
      f_out_q       <= 8'd0;
      ip_out_q      <= 16'd0;
      insn_q        <= 32'd0;
      insn_len_q    <= 4'd0;
      trace_raddr_q <= 16'd0;
      trace_rdata_q <= 8'd0;
      ip_q          <= 16'd0;
      a_q           <= 8'd0;
      f_q           <= 8'd0;
      ix_q          <= 16'd0;
      iy_q          <= 16'd0;
      prefix_q      <= 8'd0;
      opc_q         <= 8'd0;
      d_q           <= 8'd0;
      cnt_q         <= 4'd0;
    end else begin
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            ip_q       <= ip_i;
            a_q        <= a_i;
            f_q        <= f_i;
            ix_q       <= ix_i;
            iy_q       <= iy_i;
            busy_q     <= 1'b1;
            mem_rd_q   <= 1'b1;
            mem_addr_q <= ip_i;
            state_q    <= S_F0;
          end
        end
        S_F0: begin
          if (mem_ready_i) begin
            if ((mem_rdata_i == 8'hDD) || (mem_rdata_i == 8'hFD)) begin
              prefix_q   <= mem_rdata_i;
              mem_addr_q <= ip_q + 16'd1;
              state_q    <= S_F1;
            end else begin
              illegal_q <= 1'b1;
              busy_q    <= 1'b0;
              mem_rd_q  <= 1'b0;
              state_q   <= S_IDLE;
            end
          end
        end
        S_F1: begin
          if (mem_ready_i) begin
            if ((mem_rdata_i[7:6] == 2'b10) && (mem_rdata_i[2:0] == 3'b110)) begin
              opc_q      <= mem_rdata_i;
              mem_addr_q <= ip_q + 16'd2;
              state_q    <= S_F2;
            end else begin
              illegal_q <= 1'b1;
              busy_q    <= 1'b0;
              mem_rd_q  <= 1'b0;
              state_q   <= S_IDLE;
            end
          end
        end
        S_F2: begin
          if (mem_ready_i) begin
            d_q      <= mem_rdata_i;
            mem_rd_q <= 1'b0;
            cnt_q    <= CALC_LOAD;
            state_q  <= S_CALC;
          end
        end
        S_CALC: begin
          if (cnt_q == 4'd0) begin
            mem_rd_q   <= 1'b1;
            mem_addr_q <= raddr_d;
            state_q    <= S_RD;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_RD: begin
          if (mem_ready_i) begin
            mem_rd_q      <= 1'b0;
            a_out_q       <= a_d;
            f_out_q       <= f_d;
            ip_out_q      <= ip_q + 16'd3;
            insn_q        <= {8'h00, d_q, opc_q, prefix_q};
            insn_len_q    <= 4'd3;
            trace_raddr_q <= mem_addr_q;
            trace_rdata_q <= mem_rdata_i;
            done_q        <= 1'b1;
            state_q       <= S_EX;
          end
        end
        S_EX: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q   <= 1'b0;
          mem_rd_q <= 1'b0;
          state_q  <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o            = busy_q;
  assign mem_rd_o          = mem_rd_q;
  assign mem_addr_o        = mem_addr_q;
  assign done_o            = done_q;
  assign illegal_o         = illegal_q;
  assign a_o               = a_out_q;
  assign f_o               = f_out_q;
  assign ip_o              = ip_out_q;
  assign z80fi_valid_o     = done_q;
  assign z80fi_insn_o      = insn_q;
  assign z80fi_insn_len_o  = insn_len_q;
  assign z80fi_mem_raddr_o = trace_raddr_q;
  assign z80fi_mem_rdata_o = trace_rdata_q;

endmodule

// File: tb/tb_z80_exec_alu_a_idx_ixiy.sv
// Directed bench for the indexed ALU sequencer: a table of instructions
// with hand-computed results, plus stall, back-to-back, illegal-opcode
// and mid-instruction reset sequences.
module tb_z80_exec_alu_a_idx_ixiy;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] ip = 16'd0;
  logic [7:0]  a_in = 8'd0;
  logic [7:0]  f_in = 8'd0;
  logic [15:0] ix = 16'd0;
  logic [15:0] iy = 16'd0;
  logic        busy;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        mem_ready;
  logic        done;
  logic        illegal;
  logic [7:0]  a_out;
  logic [7:0]  f_out;
  logic [15:0] ip_out;
  logic        fi_valid;
  logic [31:0] fi_insn;
  logic [3:0]  fi_len;
  logic [15:0] fi_raddr;
  logic [7:0]  fi_rdata;

  int n_checks = 0;
  int n_err = 0;

  logic [7:0] mem [0:65535];
  int         stall_n = 0;
  logic [3:0] wcnt = 4'd0;

  z80_exec_alu_a_idx_ixiy #(.CALC_CYCLES(5)) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .start_i           (start),
    .ip_i              (ip),
    .a_i               (a_in),
    .f_i               (f_in),
    .ix_i              (ix),
    .iy_i              (iy),
    .busy_o            (busy),
    .mem_rd_o          (mem_rd),
    .mem_addr_o        (mem_addr),
    .mem_rdata_i       (mem_rdata),
    .mem_ready_i       (mem_ready),
    .done_o            (done),
    .illegal_o         (illegal),
    .a_o               (a_out),
    .f_o               (f_out),
    .ip_o              (ip_out),
    .z80fi_valid_o     (fi_valid),
    .z80fi_insn_o      (fi_insn),
    .z80fi_insn_len_o  (fi_len),
    .z80fi_mem_raddr_o (fi_raddr),
    .z80fi_mem_rdata_o (fi_rdata)
  );

  always #5 clk = ~clk;

  // Memory responder: each read waits stall_n cycles before ready.
  assign mem_rdata = mem[mem_addr];
  assign mem_ready = (wcnt == stall_n[3:0]);
  always @(posedge clk) begin
    if (!rst_n || (mem_rd && mem_ready)) wcnt <= 4'd0;
    else if (mem_rd) wcnt <= wcnt + 4'd1;
  end

  typedef struct {
    string       name;
    logic [15:0] ip;
    logic [7:0]  pfx;
    logic [7:0]  opc;
    logic [7:0]  d;
    logic [15:0] ix;
    logic [15:0] iy;
    logic [7:0]  a;
    logic [7:0]  f;
    logic [7:0]  m;
    logic [15:0] raddr;
    logic [7:0]  ea;
    logic [7:0]  ef;
    logic [15:0] eip;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Runs one table entry; returns at the sample where done is high.
  task automatic run_vec(input int k, input int stall, input int exp_pre, input bit poke);
    vec_t v;
    logic [15:0] a1, a2;
    logic [15:0] rd [4];
    logic [15:0] prev_addr;
    bit prev_stall;
    int nrd, pre, cyc, guard;
    bit got_done, saw_illegal;
    v = vecs[k];
    a1 = v.ip + 16'd1;
    a2 = v.ip + 16'd2;
    mem[v.ip] = v.pfx;
    mem[a1] = v.opc;
    mem[a2] = v.d;
    mem[v.raddr] = v.m;
    stall_n = stall;
    ip = v.ip; a_in = v.a; f_in = v.f; ix = v.ix; iy = v.iy;
    start = 1'b1;
    nrd = 0; pre = 0; cyc = 0; guard = 0;
    got_done = 1'b0; saw_illegal = 1'b0; prev_stall = 1'b0; prev_addr = 16'd0;
    while (!got_done && guard < 300) begin
      @(posedge clk); #1;
      guard++;
      if (cyc == 0) begin
        if (busy) begin cyc = 1; start = 1'b0; end
        else pre++;
      end else cyc++;
      if (prev_stall) begin
        check({v.name, " addr_hold"}, {15'd0, mem_rd, mem_addr}, {15'd0, 1'b1, prev_addr});
      end
      prev_stall = mem_rd && !mem_ready;
      prev_addr = mem_addr;
      if (mem_rd && mem_ready && nrd < 4) begin rd[nrd] = mem_addr; nrd++; end
      if (poke && cyc == 5) begin start = 1'b1; ip = 16'h1111; a_in = 8'h99; ix = 16'h0; iy = 16'h0; end
      if (poke && cyc == 6) start = 1'b0;
      if (illegal) saw_illegal = 1'b1;
      if (done) got_done = 1'b1;
    end
    start = 1'b0;
    check({v.name, " done_seen"}, {31'd0, got_done}, 32'd1);
    check({v.name, " no_illegal"}, {31'd0, saw_illegal}, 32'd0);
    check({v.name, " pre_cycles"}, pre, exp_pre);
    check({v.name, " done_cycle"}, cyc, 10 + 4 * stall);
    check({v.name, " a"}, {24'd0, a_out}, {24'd0, v.ea});
    check({v.name, " f"}, {24'd0, f_out}, {24'd0, v.ef});
    check({v.name, " ip_out"}, {16'd0, ip_out}, {16'd0, v.eip});
    check({v.name, " fi_valid"}, {31'd0, fi_valid}, 32'd1);
    check({v.name, " fi_insn"}, fi_insn, {8'h00, v.d, v.opc, v.pfx});
    check({v.name, " fi_len"}, {28'd0, fi_len}, 32'd3);
    check({v.name, " fi_raddr"}, {16'd0, fi_raddr}, {16'd0, v.raddr});
    check({v.name, " fi_rdata"}, {24'd0, fi_rdata}, {24'd0, v.m});
    check({v.name, " n_reads"}, nrd, 4);
    if (nrd == 4) begin
      check({v.name, " rd0"}, {16'd0, rd[0]}, {16'd0, v.ip});
      check({v.name, " rd1"}, {16'd0, rd[1]}, {16'd0, a1});
      check({v.name, " rd2"}, {16'd0, rd[2]}, {16'd0, a2});
      check({v.name, " rd3"}, {16'd0, rd[3]}, {16'd0, v.raddr});
    end
    $display("vec %-5s A=%h F=%h ip_out=%h raddr=%h cycle=%0d", v.name, a_out, f_out, ip_out, fi_raddr, cyc);
  endtask

  // One idle cycle after a completed instruction; done must have dropped.
  task automatic idle_cycle(input string name);
    @(posedge clk); #1;
    check({name, " done_pulse_1cyc"}, {30'd0, done, busy}, 32'd0);
  endtask

  task automatic run_illegal(input string name, input logic [15:0] at, input logic [7:0] b0,
                             input logic [7:0] b1, input int exp_cyc);
    logic [15:0] a1;
    int cyc, ill_cyc, n_ill, n_done;
    a1 = at + 16'd1;
    mem[at] = b0;
    mem[a1] = b1;
    stall_n = 0;
    ip = at;
    start = 1'b1;
    cyc = 0; ill_cyc = -1; n_ill = 0; n_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      cyc++;
      start = 1'b0;
      if (illegal) begin n_ill++; if (ill_cyc < 0) ill_cyc = cyc; end
      if (done) n_done++;
    end
    check({name, " illegal_cycle"}, ill_cyc, exp_cyc);
    check({name, " illegal_count"}, n_ill, 1);
    check({name, " no_done"}, n_done, 0);
    check({name, " idle_after"}, {31'd0, busy}, 32'd0);
    $display("illegal %s bytes=%h %h at cycle %0d", name, b0, b1, ill_cyc);
  endtask

  initial begin
    int cyc;
    int n_done;
    //           name    ip        pfx    opc    d      ix        iy        a      f      m      raddr     A      F      ip_out
    vecs[0]  = '{"add",  16'h0100, 8'hDD, 8'h86, 8'h05, 16'h2000, 16'h0000, 8'h44, 8'h00, 8'h11, 16'h2005, 8'h55, 8'h00, 16'h0103};
    vecs[1]  = '{"sub",  16'h0200, 8'hFD, 8'h96, 8'hFF, 16'h1234, 16'h3000, 8'h80, 8'h28, 8'h01, 16'h2FFF, 8'h7F, 8'h3E, 16'h0203};
    vecs[2]  = '{"adc",  16'h0300, 8'hDD, 8'h8E, 8'h00, 16'h4000, 16'h0000, 8'hFF, 8'h01, 8'h00, 16'h4000, 8'h00, 8'h51, 16'h0303};
    vecs[3]  = '{"xor",  16'h0400, 8'hDD, 8'hAE, 8'h00, 16'h5000, 16'h0000, 8'h5A, 8'h00, 8'h5A, 16'h5000, 8'h00, 8'h44, 16'h0403};
    vecs[4]  = '{"wrap", 16'hFFFE, 8'hDD, 8'h86, 8'h02, 16'hFFFF, 16'h0000, 8'h10, 8'h00, 8'h01, 16'h0001, 8'h11, 8'h00, 16'h0001};
    vecs[5]  = '{"sbc",  16'h0500, 8'hFD, 8'h9E, 8'h10, 16'h0000, 16'h6000, 8'h20, 8'h01, 8'h0F, 16'h6010, 8'h10, 8'h12, 16'h0503};
    vecs[6]  = '{"and",  16'h0600, 8'hDD, 8'hA6, 8'hFE, 16'h7002, 16'h0000, 8'hF3, 8'hFF, 8'h0F, 16'h7000, 8'h03, 8'h3C, 16'h0603};
    vecs[7]  = '{"or",   16'h0700, 8'hFD, 8'hB6, 8'h7F, 16'h0000, 16'h8000, 8'h01, 8'h00, 8'h80, 16'h807F, 8'h81, 8'h84, 16'h0703};
    vecs[8]  = '{"cp",   16'h0800, 8'hDD, 8'hBE, 8'h01, 16'h9000, 16'h0000, 8'h20, 8'h00, 8'h20, 16'h9001, 8'h20, 8'h42, 16'h0803};
    vecs[9]  = '{"addv", 16'h0900, 8'hDD, 8'h86, 8'h00, 16'hA000, 16'h0000, 8'h7F, 8'h00, 8'h01, 16'hA000, 8'h80, 8'h94, 16'h0903};
    vecs[10] = '{"subc", 16'h0A00, 8'hFD, 8'h96, 8'h00, 16'h0000, 16'hB000, 8'h01, 8'h00, 8'h02, 16'hB000, 8'hFF, 8'h93, 16'h0A03};

    // Reset state.
    #12;
    check("reset_ctrl", {28'd0, busy, mem_rd, done, illegal}, 32'd0);
    check("reset_data", {a_out, f_out, ip_out}, 32'd0);
    check("reset_trace", {fi_valid, fi_len, fi_raddr, fi_rdata}, 29'd0);
    check("reset_insn", fi_insn, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table of instructions with single-cycle memory.
    for (int k = 0; k < 11; k++) begin
      run_vec(k, 0, 0, 1'b0);
      idle_cycle(vecs[k].name);
    end

    // Three wait cycles per read, plus a start pulse while busy that must be ignored.
    run_vec(0, 3, 0, 1'b1);
    idle_cycle("stall");

    // Back-to-back: start held from the done cycle is taken in the cycle after.
    run_vec(1, 0, 0, 1'b0);
    run_vec(3, 0, 1, 1'b0);
    idle_cycle("b2b");

    // Illegal encodings.
    run_illegal("ed_prefix", 16'hC000, 8'hED, 8'h86, 2);
    run_illegal("bad_low3", 16'hC100, 8'hDD, 8'h87, 3);
    run_illegal("bad_hi2", 16'hC200, 8'hFD, 8'h46, 3);

    // Reset during CALC aborts the instruction.
    stall_n = 0;
    ip = vecs[0].ip; a_in = vecs[0].a; f_in = vecs[0].f; ix = vecs[0].ix; iy = vecs[0].iy;
    start = 1'b1;
    cyc = 0;
    for (int i = 0; i < 20 && cyc < 6; i++) begin
      @(posedge clk); #1;
      if (busy) begin start = 1'b0; cyc++; end
    end
    rst_n = 1'b0;
    #1;
    check("rst_mid_ctrl", {28'd0, busy, mem_rd, done, illegal}, 32'd0);
    check("rst_mid_data", {a_out, f_out, ip_out}, 32'd0);
    check("rst_mid_trace", {fi_valid, fi_len, fi_raddr, fi_rdata, mem_addr}, 45'd0);
    n_done = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (done || illegal) n_done++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (done || illegal || busy) n_done++;
    end
    check("rst_mid_no_done", n_done, 0);
    $display("reset during CALC: outputs cleared, no pulse");
    run_vec(0, 0, 0, 1'b0);
    idle_cycle("after_reset");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
